// File: rtl/adam_syscfg_tgt_ctrl_if.sv
// APB slave bundle between the system-config bridge and one target
// control stage. The bridge side drives requests, the target stage answers.
interface adam_syscfg_tgt_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/adam_syscfg_tgt_ctrl.sv
// Per-target control stage: holds one target's control registers, sequences
// its reset line and 4-phase pause handshake, and drives its boot address and
// masked interrupt line.
//
// state         | meaning
// --------------+---------------------------------------------------------
// STOPPED   (0) | target held in reset and paused, waits for run intent
// PAUSED    (1) | out of reset, pause request asserted
// RESUMING  (2) | pause request dropped, waiting for target ack to fall
// RUNNING   (3) | target running freely
// PAUSING   (4) | pause request raised, waiting for target ack
// RESETTING (5) | target reset asserted for RST_CYCLES, then STOPPED
module adam_syscfg_tgt_ctrl #(
  parameter int unsigned            ADDR_WIDTH    = 32,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter bit                     EN_BOOTSTRAP  = 1'b0,
  parameter bit                     EN_BOOT_ADDR  = 1'b0,
  parameter bit                     EN_IRQ        = 1'b0,
  parameter int unsigned            RST_CYCLES    = 4,
  parameter logic [DATA_WIDTH-1:0]  BOOT_ADDR_RST = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adam_syscfg_tgt_ctrl_if.slave   apb,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic [DATA_WIDTH-1:0]   irq_vec,
  output logic                    tgt_rst,
  output logic                    tgt_pause_req,
  input  logic                    tgt_pause_ack,
  output logic [DATA_WIDTH-1:0]   tgt_boot_addr,
  output logic                    tgt_irq
);

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_PAUSED    = 3'd1,
    ST_RESUMING  = 3'd2,
    ST_RUNNING   = 3'd3,
    ST_PAUSING   = 3'd4,
    ST_RESETTING = 3'd5
  } state_e;

  localparam logic [1:0] REG_ACTION    = 2'd0;
  localparam logic [1:0] REG_STATUS    = 2'd1;
  localparam logic [1:0] REG_BOOT_ADDR = 2'd2;
  localparam logic [1:0] REG_IRQ_MASK  = 2'd3;

  localparam logic [1:0] ACT_RESUME = 2'd1;
  localparam logic [1:0] ACT_PAUSE  = 2'd2;
  localparam logic [1:0] ACT_STOP   = 2'd3;

  // Reset residency is timed by a down-counter loaded with RST_CYCLES-1;
  // the target leaves RESETTING on the cycle the counter reads zero.
  localparam int unsigned     CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [CNT_W-1:0]        rst_cnt_q;
  logic                    want_run_q;
  logic                    stop_pend_q;
  logic                    pause_ack_q;
  logic                    tgt_irq_q;
  logic [DATA_WIDTH-1:0]   boot_addr_q;
  logic [DATA_WIDTH-1:0]   irq_mask_q;

  logic                    access;
  logic [1:0]              reg_sel;
  logic [1:0]              act_code;
  logic                    reg_err;
  logic [DATA_WIDTH-1:0]   reg_rdata;
  logic                    wr_ok;
  logic                    act_resume;
  logic                    act_pause;
  logic                    act_stop;
  logic                    rst_done;
  logic [5:0]              status_bits;
  logic                    unused_paddr;

  // ---------------------------------------------------------------------
  // Register access decode
  // ---------------------------------------------------------------------
  assign access       = apb.psel & apb.penable;
  assign reg_sel      = apb.paddr[3:2];
  assign act_code     = apb.pwdata[1:0];
  assign unused_paddr = ^{apb.paddr[ADDR_WIDTH-1:4], apb.paddr[1:0]};

  assign status_bits  = {pause_ack_q, stop_pend_q, want_run_q, state_q};

  // Classify the current access as legal/illegal and select read data.
  always_comb begin
    reg_err   = 1'b0;
    reg_rdata = '0;
    case (reg_sel)
      REG_ACTION: begin
        // write-only; code 0 is not a command
        reg_err = !apb.pwrite || (act_code == 2'd0);
      end
      REG_STATUS: begin
        if (apb.pwrite) reg_err = 1'b1;
        else            reg_rdata = DATA_WIDTH'(status_bits);
      end
      REG_BOOT_ADDR: begin
        if (!EN_BOOT_ADDR)    reg_err = 1'b1;
        else if (!apb.pwrite) reg_rdata = boot_addr_q;
      end
      REG_IRQ_MASK: begin
        if (!EN_IRQ)          reg_err = 1'b1;
        else if (!apb.pwrite) reg_rdata = irq_mask_q;
      end
      default: reg_err = 1'b1;
    endcase
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & reg_err;
  assign apb.prdata  = (access && !apb.pwrite) ? reg_rdata : '0;

  assign wr_ok      = access & apb.pwrite & !reg_err;
  assign act_resume = wr_ok && (reg_sel == REG_ACTION) && (act_code == ACT_RESUME);
  assign act_pause  = wr_ok && (reg_sel == REG_ACTION) && (act_code == ACT_PAUSE);
  assign act_stop   = wr_ok && (reg_sel == REG_ACTION) && (act_code == ACT_STOP);

  // ---------------------------------------------------------------------
  // Software intent. A command arriving on the same cycle the FSM finishes
  // a reset overrides the FSM's clear of stop_pend (later assignment wins).
  // ---------------------------------------------------------------------
  // Track run intent and pending stop from ACTION commands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      want_run_q  <= EN_BOOTSTRAP;
      stop_pend_q <= 1'b0;
    end else begin
      if (rst_done) stop_pend_q <= 1'b0;
      if (act_resume) begin
        want_run_q  <= 1'b1;
        stop_pend_q <= 1'b0;
      end
      if (act_pause) want_run_q <= 1'b0;
      if (act_stop) begin
        want_run_q  <= 1'b0;
        stop_pend_q <= 1'b1;
      end
    end
  end

  // Hold the boot address and interrupt mask configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_addr_q <= BOOT_ADDR_RST;
      irq_mask_q  <= '0;
    end else if (wr_ok) begin
      if (reg_sel == REG_BOOT_ADDR) boot_addr_q <= apb.pwdata;
      if (reg_sel == REG_IRQ_MASK)  irq_mask_q  <= apb.pwdata;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  assign rst_done = (state_q == ST_RESETTING) && (rst_cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_STOPPED;
    else        state_q <= state_d;
  end

  // Next-state logic; pause_req acts as a hold that blocks forward progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (want_run_q && !pause_req) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (stop_pend_q)                    state_d = ST_RESETTING;
        else if (want_run_q && !pause_req)  state_d = ST_RESUMING;
      end
      ST_RESUMING: begin
        // must finish the handshake before the target can be paused again
        if (!tgt_pause_ack) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (!want_run_q || pause_req) state_d = ST_PAUSING;
      end
      ST_PAUSING: begin
        if (tgt_pause_ack) state_d = stop_pend_q ? ST_RESETTING : ST_PAUSED;
      end
      ST_RESETTING: begin
        if (rst_cnt_q == '0) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Decode target reset and pause request from the registered state.
  always_comb begin
    tgt_rst       = 1'b1;
    tgt_pause_req = 1'b1;
    case (state_q)
      ST_STOPPED, ST_RESETTING: begin
        tgt_rst       = 1'b1;
        tgt_pause_req = 1'b1;
      end
      ST_PAUSED, ST_PAUSING: begin
        tgt_rst       = 1'b0;
        tgt_pause_req = 1'b1;
      end
      ST_RESUMING, ST_RUNNING: begin
        tgt_rst       = 1'b0;
        tgt_pause_req = 1'b0;
      end
      default: begin
        tgt_rst       = 1'b1;
        tgt_pause_req = 1'b1;
      end
    endcase
  end

  // Reset-residency timer: reloads outside RESETTING, counts down inside.
  always_ff @(posedge clk) begin
    if (!rst_n)                          rst_cnt_q <= CNT_LOAD;
    else if (state_q != ST_RESETTING)    rst_cnt_q <= CNT_LOAD;
    else if (rst_cnt_q != '0)            rst_cnt_q <= rst_cnt_q - 1'b1;
  end

  // ---------------------------------------------------------------------
  // System pause acknowledge and interrupt
  // ---------------------------------------------------------------------
  // Acknowledge the system hold only once the target is quiescent.
  always_ff @(posedge clk) begin
    if (!rst_n) pause_ack_q <= 1'b0;
    else        pause_ack_q <= pause_req &&
                               ((state_q == ST_STOPPED) || (state_q == ST_PAUSED));
  end

  // Register the masked interrupt reduction.
  always_ff @(posedge clk) begin
    if (!rst_n)      tgt_irq_q <= 1'b0;
    else if (EN_IRQ) tgt_irq_q <= |(irq_vec & irq_mask_q);
    else             tgt_irq_q <= 1'b0;
  end

  assign pause_ack     = pause_ack_q;
  assign tgt_irq       = tgt_irq_q;
  assign tgt_boot_addr = EN_BOOT_ADDR ? boot_addr_q : '0;

endmodule
